// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the shared 16-bit memory port: fixed priority dm > if > ld,
// a starvation override for the loader, and MEM_LAT-cycle sequencing of each access.
module mem_port_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [15:0] dm_addr_i,
  input  logic [15:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  input  logic        ld_req_i,
  input  logic        ld_we_i,
  input  logic [15:0] ld_addr_i,
  input  logic [15:0] ld_wdata_i,
  output logic        ld_gnt_o,
  output logic        ld_rvalid_o,
  output logic [15:0] rdata_o,
  output logic        busy_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);
  typedef enum logic {IDLE, BUSY} state_e;

  // id is one-hot {ld, dm, if} so it maps straight onto the gnt/rvalid strobes
  typedef struct packed {
    logic [2:0]  id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  acc_t        acc_q, acc_d;
  logic [3:0]  ld_wait_q, ld_wait_d;
  logic [15:0] rdata_q, rdata_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  rvalid_q, rvalid_d;
  logic        any_req, ld_force;
  logic [2:0]  win;

  always_comb begin
    any_req  = if_req_i | dm_req_i | ld_req_i;
    ld_force = ld_req_i && (ld_wait_q == WAIT_MAX);
    if (ld_force || !(dm_req_i || if_req_i)) win = 3'b100;
    else if (dm_req_i)                       win = 3'b010;
    else                                     win = 3'b001;
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    acc_d     = acc_q;
    ld_wait_d = ld_wait_q;
    rdata_d   = rdata_q;
    gnt_d     = '0;
    rvalid_d  = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = BUSY;
          lat_d    = LAT_INIT;
          gnt_d    = win;
          acc_d.id = win;
          if (win[2]) begin
            acc_d.we    = ld_we_i;
            acc_d.addr  = ld_addr_i;
            acc_d.wdata = ld_wdata_i;
          end else if (win[1]) begin
            acc_d.we    = dm_we_i;
            acc_d.addr  = dm_addr_i;
            acc_d.wdata = dm_wdata_i;
          end else begin
            acc_d.we    = 1'b0;
            acc_d.addr  = if_addr_i;
            acc_d.wdata = '0;
          end
          // loader loss counter only moves when an arbitration actually happens
          if (ld_req_i && !win[2])
            ld_wait_d = (ld_wait_q == WAIT_MAX) ? ld_wait_q : ld_wait_q + 4'd1;
          else
            ld_wait_d = '0;
        end
      end
      BUSY: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          if (!acc_q.we) begin
            rdata_d  = mem_rdata_i;
            rvalid_d = acc_q.id;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      acc_q     <= '0;
      ld_wait_q <= '0;
      rdata_q   <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      acc_q     <= acc_d;
      ld_wait_q <= ld_wait_d;
      rdata_q   <= rdata_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign mem_en_o    = busy_o;
  assign mem_we_o    = busy_o & acc_q.we;
  assign mem_addr_o  = busy_o ? acc_q.addr  : '0;
  assign mem_wdata_o = busy_o ? acc_q.wdata : '0;
  assign rdata_o     = rdata_q;
  assign if_gnt_o    = gnt_q[0];
  assign dm_gnt_o    = gnt_q[1];
  assign ld_gnt_o    = gnt_q[2];
  assign if_rvalid_o = rvalid_q[0];
  assign dm_rvalid_o = rvalid_q[1];
  assign ld_rvalid_o = rvalid_q[2];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1/MAX_WAIT=4, MEM_LAT=3/MAX_WAIT=2)
// checked every cycle against a transaction-schedule model, plus directed literal checks.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // requester index: 0 = fetch, 1 = data, 2 = loader
  logic        rst   [2];
  logic        req   [2][3];
  logic        we    [2][3];
  logic [15:0] addr  [2][3];
  logic [15:0] wd    [2][3];
  logic        gnt   [2][3];
  logic        rv    [2][3];
  logic [15:0] rdata [2];
  logic [15:0] maddr [2];
  logic [15:0] mwdat [2];
  logic [15:0] mrdat [2];
  logic        busy  [2];
  logic        men   [2];
  logic        mwe   [2];

  logic [15:0] mem [2][256];
  logic [15:0] mm  [2][256];

  assign mrdat[0] = mem[0][maddr[0][7:0]];
  assign mrdat[1] = mem[1][maddr[1][7:0]];

  mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) u_l1 (
    .clk_i(clk), .rst_i(rst[0]),
    .if_req_i(req[0][0]), .if_addr_i(addr[0][0]), .if_gnt_o(gnt[0][0]), .if_rvalid_o(rv[0][0]),
    .dm_req_i(req[0][1]), .dm_we_i(we[0][1]), .dm_addr_i(addr[0][1]), .dm_wdata_i(wd[0][1]),
    .dm_gnt_o(gnt[0][1]), .dm_rvalid_o(rv[0][1]),
    .ld_req_i(req[0][2]), .ld_we_i(we[0][2]), .ld_addr_i(addr[0][2]), .ld_wdata_i(wd[0][2]),
    .ld_gnt_o(gnt[0][2]), .ld_rvalid_o(rv[0][2]),
    .rdata_o(rdata[0]), .busy_o(busy[0]), .mem_en_o(men[0]), .mem_we_o(mwe[0]),
    .mem_addr_o(maddr[0]), .mem_wdata_o(mwdat[0]), .mem_rdata_i(mrdat[0]));

  mem_port_arbiter #(.MEM_LAT(3), .MAX_WAIT(2)) u_l3 (
    .clk_i(clk), .rst_i(rst[1]),
    .if_req_i(req[1][0]), .if_addr_i(addr[1][0]), .if_gnt_o(gnt[1][0]), .if_rvalid_o(rv[1][0]),
    .dm_req_i(req[1][1]), .dm_we_i(we[1][1]), .dm_addr_i(addr[1][1]), .dm_wdata_i(wd[1][1]),
    .dm_gnt_o(gnt[1][1]), .dm_rvalid_o(rv[1][1]),
    .ld_req_i(req[1][2]), .ld_we_i(we[1][2]), .ld_addr_i(addr[1][2]), .ld_wdata_i(wd[1][2]),
    .ld_gnt_o(gnt[1][2]), .ld_rvalid_o(rv[1][2]),
    .rdata_o(rdata[1]), .busy_o(busy[1]), .mem_en_o(men[1]), .mem_we_o(mwe[1]),
    .mem_addr_o(maddr[1]), .mem_wdata_o(mwdat[1]), .mem_rdata_i(mrdat[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int mw_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction
  function automatic logic [15:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    return (a == 16) ? 16'hA5A5 : {b, ~b};
  endfunction

  // model: each access is a scheduled window [st, en] plus an optional read return at rvc
  int          cyc;
  int          st [2], en [2], rvc [2], lw [2], mid [2], wcnt [2];
  logic [15:0] ma [2], mwd [2], rvd [2], rdc [2];
  bit          mwe_m [2], wpend [2];
  bit          e_gnt [2][3], e_rv [2][3], e_busy [2], e_we [2];
  logic [15:0] e_addr [2], e_wd [2], e_rd [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s u%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 3; r++) begin
          chk($sformatf("gnt%0d", r), k, 16'(gnt[k][r]), 16'(e_gnt[k][r]));
          chk($sformatf("rvalid%0d", r), k, 16'(rv[k][r]), 16'(e_rv[k][r]));
        end
        chk("busy", k, 16'(busy[k]), 16'(e_busy[k]));
        chk("mem_en", k, 16'(men[k]), 16'(e_busy[k]));
        chk("mem_we", k, 16'(mwe[k]), 16'(e_we[k]));
        chk("mem_addr", k, maddr[k], e_addr[k]);
        chk("mem_wdata", k, mwdat[k], e_wd[k]);
        chk("rdata", k, rdata[k], e_rd[k]);
      end
    end
  end

  task automatic model_reset(input int k);
    if (wpend[k] && cyc == en[k]) mm[k][ma[k][7:0]] = mwd[k];
    st[k] = -100; en[k] = -100; rvc[k] = -1; rdc[k] = '0; lw[k] = 0; wpend[k] = 1'b0;
  endtask

  // inputs of the current cycle are final: decide whether an arbitration happens now
  task automatic model_pre(input int k);
    int w;
    bit any, force_ld;
    if (rst[k]) begin
      model_reset(k);
      return;
    end
    any = req[k][0] || req[k][1] || req[k][2];
    if (!any || (cyc >= st[k] && cyc <= en[k])) return;
    force_ld = req[k][2] && (lw[k] == mw_of(k));
    w = force_ld ? 2 : req[k][1] ? 1 : req[k][0] ? 0 : 2;
    if (req[k][2] && w != 2) lw[k] = (lw[k] < mw_of(k)) ? lw[k] + 1 : lw[k];
    else lw[k] = 0;
    mid[k]   = w;
    ma[k]    = addr[k][w];
    mwd[k]   = (w == 0) ? 16'h0 : wd[k][w];
    mwe_m[k] = (w != 0) && we[k][w];
    st[k]    = cyc + 1;
    en[k]    = cyc + lat_of(k);
    if (mwe_m[k]) wpend[k] = 1'b1;
    else begin
      rvc[k] = cyc + lat_of(k) + 1;
      rvd[k] = mm[k][ma[k][7:0]];
    end
  endtask

  task automatic model_post(input int k);
    bit b;
    if (wpend[k] && cyc == en[k] + 1) begin
      mm[k][ma[k][7:0]] = mwd[k];
      wpend[k] = 1'b0;
    end
    if (cyc == rvc[k]) rdc[k] = rvd[k];
    b = (cyc >= st[k]) && (cyc <= en[k]);
    for (int r = 0; r < 3; r++) begin
      e_gnt[k][r] = (cyc == st[k]) && (mid[k] == r);
      e_rv[k][r]  = (cyc == rvc[k]) && (mid[k] == r);
    end
    e_busy[k] = b;
    e_we[k]   = b && mwe_m[k];
    e_addr[k] = b ? ma[k] : 16'h0;
    e_wd[k]   = b ? mwd[k] : 16'h0;
    e_rd[k]   = rdc[k];
  endtask

  // memory commits a write once mem_we has been held for the full access
  task automatic tick();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (men[k] && mwe[k]) begin
        wcnt[k]++;
        if (wcnt[k] == lat_of(k)) mem[k][maddr[k][7:0]] = mwdat[k];
      end else begin
        wcnt[k] = 0;
      end
      model_pre(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) model_post(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic new_req(input int k, input int r);
    req[k][r]  = 1'b1;
    addr[k][r] = {8'($urandom_range(0, 255)), 4'h0, 4'($urandom_range(0, 15))};
    we[k][r]   = 1'($urandom_range(0, 1));
    wd[k][r]   = 16'($urandom);
  endtask

  task automatic drive_rand(input int k);
    rst[k] = ($urandom_range(0, 249) == 0);
    for (int r = 0; r < 3; r++) begin
      if (req[k][r]) begin
        if (gnt[k][r]) begin
          if ($urandom_range(0, 1) == 1) new_req(k, r);
          else req[k][r] = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        new_req(k, r);
      end
    end
  endtask

  int c0, first_ld, second_ld;

  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      for (int r = 0; r < 3; r++) begin
        req[k][r] = 1'b0; we[k][r] = 1'b0; addr[k][r] = '0; wd[k][r] = '0;
      end
      for (int a = 0; a < 256; a++) begin
        mem[k][a] = init_val(a);
        mm[k][a]  = init_val(a);
      end
      wcnt[k] = 0; mid[k] = 0; ma[k] = '0; mwd[k] = '0; mwe_m[k] = 1'b0; rvd[k] = '0;
      model_reset(k);
    end
    tick();
    chk_en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset busy", k, 16'(busy[k]), 16'h0);
      chk("reset rdata", k, rdata[k], 16'h0);
      chk("reset mem_addr", k, maddr[k], 16'h0);
      rst[k] = 1'b0;
    end
    idle(2);

    // single fetch, MEM_LAT=1
    req[0][0] = 1'b1; addr[0][0] = 16'h0010;
    tick();
    chk("t1 if_gnt", 0, 16'(gnt[0][0]), 16'h1);
    chk("t1 mem_en", 0, 16'(men[0]), 16'h1);
    chk("t1 mem_addr", 0, maddr[0], 16'h0010);
    req[0][0] = 1'b0;
    tick();
    chk("t1 if_rvalid", 0, 16'(rv[0][0]), 16'h1);
    chk("t1 rdata", 0, rdata[0], 16'hA5A5);

    // dm beats if; if is granted once the port frees up
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 16'h0020;
    req[0][0] = 1'b1; addr[0][0] = 16'h0030;
    tick();
    chk("t2 dm_gnt", 0, 16'(gnt[0][1]), 16'h1);
    chk("t2 if_gnt early", 0, 16'(gnt[0][0]), 16'h0);
    req[0][1] = 1'b0;
    tick();
    chk("t2 dm_rvalid", 0, 16'(rv[0][1]), 16'h1);
    chk("t2 dm rdata", 0, rdata[0], 16'h20DF);
    tick();
    chk("t2 if_gnt", 0, 16'(gnt[0][0]), 16'h1);
    req[0][0] = 1'b0;
    tick();
    chk("t2 if rdata", 0, rdata[0], 16'h30CF);
    idle(2);

    // loader starvation guard, MAX_WAIT=4: win on the 5th arbitration, then count restarts
    req[0][1] = 1'b1; addr[0][1] = 16'h0001; we[0][1] = 1'b0;
    req[0][0] = 1'b1; addr[0][0] = 16'h0002;
    req[0][2] = 1'b1; addr[0][2] = 16'h0003; we[0][2] = 1'b0;
    c0 = cyc; first_ld = -1; second_ld = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt[0][2]) begin
        if (first_ld < 0) first_ld = cyc - c0;
        else if (second_ld < 0) second_ld = cyc - c0;
      end
    end
    chk("t3 first ld_gnt offset", 0, 16'(first_ld), 16'd9);
    chk("t3 second ld_gnt offset", 0, 16'(second_ld), 16'd19);
    req[0][0] = 1'b0; req[0][1] = 1'b0; req[0][2] = 1'b0;
    idle(3);

    // loader write, MEM_LAT=3
    req[1][2] = 1'b1; we[1][2] = 1'b1; addr[1][2] = 16'h0100; wd[1][2] = 16'h1234;
    tick();
    chk("t4 ld_gnt", 1, 16'(gnt[1][2]), 16'h1);
    chk("t4 mem_we c1", 1, 16'(mwe[1]), 16'h1);
    chk("t4 mem_addr", 1, maddr[1], 16'h0100);
    chk("t4 mem_wdata", 1, mwdat[1], 16'h1234);
    req[1][2] = 1'b0; we[1][2] = 1'b0;
    tick();
    tick();
    chk("t4 mem_we c3", 1, 16'(mwe[1]), 16'h1);
    tick();
    chk("t4 busy c4", 1, 16'(busy[1]), 16'h0);
    chk("t4 ld_rvalid", 1, 16'(rv[1][2]), 16'h0);
    req[1][0] = 1'b1; addr[1][0] = 16'h0100;
    tick();
    req[1][0] = 1'b0;
    idle(3);
    chk("t4 readback rvalid", 1, 16'(rv[1][0]), 16'h1);
    chk("t4 readback rdata", 1, rdata[1], 16'h1234);
    idle(1);

    // reset in the middle of a MEM_LAT=3 read
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 16'h0040;
    tick();
    req[1][1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("t5 busy after rst", 1, 16'(busy[1]), 16'h0);
    chk("t5 mem_en after rst", 1, 16'(men[1]), 16'h0);
    chk("t5 rdata after rst", 1, rdata[1], 16'h0);
    req[1][0] = 1'b1; addr[1][0] = 16'h0050;
    tick();
    chk("t5 if_gnt after rst", 1, 16'(gnt[1][0]), 16'h1);
    chk("t5 no dm_rvalid", 1, 16'(rv[1][1]), 16'h0);
    req[1][0] = 1'b0;
    idle(3);
    chk("t5 if rdata", 1, rdata[1], 16'h50AF);
    idle(2);

    // back-to-back: rvalid and the next arbitration share a cycle
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 16'h0060;
    tick();
    req[0][1] = 1'b0;
    req[0][0] = 1'b1; addr[0][0] = 16'h0070;
    tick();
    chk("t6 dm_rvalid", 0, 16'(rv[0][1]), 16'h1);
    chk("t6 busy gap", 0, 16'(busy[0]), 16'h0);
    tick();
    chk("t6 if_gnt", 0, 16'(gnt[0][0]), 16'h1);
    req[0][0] = 1'b0;
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      drive_rand(0);
      drive_rand(1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      for (int r = 0; r < 3; r++) req[k][r] = 1'b0;
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
